spi_tx_arbiter: RTL

- Round-robin, packet-atomic arbiter that shares the single SPI sub TX byte stream between several response sources in the command pipeline, e.g. command responder, status reporter and debug readback.
- Once a requester is granted, it holds the stream until its last byte is accepted. This prevents interleaved responses on MISO.
- Output is a registered ready/valid stage that feeds the SPI sub tx_in interface directly.
- A stall watchdog releases a grant held by a requester that stops supplying bytes mid-packet.

---
 rtl/spi_tx_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/spi_tx_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one SPI TX byte stream.
// Registered output stage plus a stall watchdog that frees a hung grant.
module spi_tx_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int WORD_SIZE      = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                         clk_system,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*WORD_SIZE-1:0] req_data,
   input  logic [NUM_REQ-1:0]           req_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WORD_SIZE-1:0]         out_data,
   output logic                         out_last,
   output logic [NUM_REQ-1:0]           grant,
   output logic                         busy,
   output logic                         timeout_err,
   input  logic                         err_clear
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CMAX  = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [IW-1:0] ILAST = IW'(NUM_REQ - 1);

   typedef enum logic {IDLE, ACTIVE} state_e;

   state_e               state_q;
   logic [IW-1:0]        ptr_q;
   logic [IW-1:0]        gidx_q;
   logic [NUM_REQ-1:0]   grant_q;
   logic [CW-1:0]        cnt_q;
   logic                 ov_q;
   logic [WORD_SIZE-1:0] od_q;
   logic                 ol_q;
   logic                 terr_q;

   logic [WORD_SIZE-1:0] words [NUM_REQ];
   logic                 g_valid;
   logic                 g_last;
   logic [WORD_SIZE-1:0] g_data;
   logic                 rdy;
   logic                 hs;
   logic                 found;
   logic [IW-1:0]        sel;
   logic [IW-1:0]        ptr_d;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         words[i] = req_data[i*WORD_SIZE +: WORD_SIZE];
      end
   end

   assign g_valid   = req_valid[gidx_q];
   assign g_last    = req_last[gidx_q];
   assign g_data    = words[gidx_q];
   assign rdy       = (state_q == ACTIVE) & (!ov_q | out_ready);
   assign hs        = rdy & g_valid;
   assign req_ready = rdy ? grant_q : '0;
   assign ptr_d     = (gidx_q == ILAST) ? '0 : gidx_q + IW'(1);

   // First requester at or above the pointer, wrapping around.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_valid[(i + int'(ptr_q)) % NUM_REQ]) begin
            found = 1'b1;
            sel   = IW'((i + int'(ptr_q)) % NUM_REQ);
         end
      end
   end

   always_ff @(posedge clk_system or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gidx_q  <= '0;
         grant_q <= '0;
         cnt_q   <= '0;
         ov_q    <= 1'b0;
         od_q    <= '0;
         ol_q    <= 1'b0;
         terr_q  <= 1'b0;
      end else begin
         if (hs) begin
            ov_q <= 1'b1;
            od_q <= g_data;
            ol_q <= g_last;
         end else if (out_ready) begin
            ov_q <= 1'b0;
         end
         if (err_clear) terr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (found) begin
                  state_q <= ACTIVE;
                  gidx_q  <= sel;
                  grant_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
               end
            end
            ACTIVE: begin
               if (hs && g_last) begin
                  state_q <= IDLE;
                  ptr_q   <= ptr_d;
                  grant_q <= '0;
                  cnt_q   <= '0;
               end else if (g_valid) begin
                  cnt_q <= '0;
               end else if (cnt_q == CMAX) begin
                  // Watchdog release; a same-cycle clear loses to this set.
                  state_q <= IDLE;
                  ptr_q   <= ptr_d;
                  grant_q <= '0;
                  terr_q  <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
         endcase
      end
   end

   assign out_valid   = ov_q;
   assign out_data    = od_q;
   assign out_last    = ol_q;
   assign grant       = grant_q;
   assign busy        = (state_q == ACTIVE);
   assign timeout_err = terr_q;

endmodule
